// File: rtl/jtkicker_objrom_pkg.sv
// rtl/jtkicker_objrom_pkg.sv - shared widths and FSM state encodings for the object ROM responder
package jtkicker_objrom_pkg;

    localparam int SDRAM_AW = 22;
    localparam int DW       = 32;
    localparam int BEAT_W   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT_LO = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_PF_REQ  = 3'd4;
    localparam logic [2:0] ST_PF_LO   = 3'd5;
    localparam logic [2:0] ST_PF_HI   = 3'd6;

endpackage

// File: rtl/jtkicker_objrom_entry.sv
// rtl/jtkicker_objrom_entry.sv - one cached 32-bit word: tag/valid/data with hit compare, load and clear
module jtkicker_objrom_entry
    import jtkicker_objrom_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          load_valid,
    input  logic [AW-1:0] load_tag,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] cmp_addr,
    output logic          hit,
    output logic          valid,
    output logic [AW-1:0] tag,
    output logic [DW-1:0] data
);

    assign hit = valid && (tag == cmp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end
            // a clear in the same cycle as a load still wins over validity
            if (load) begin
                valid <= load_valid & ~clr;
                tag   <= load_tag;
                data  <= load_data;
            end
        end
    end

endmodule

// File: rtl/jtkicker_objrom_resp.sv
// rtl/jtkicker_objrom_resp.sv - object ROM fetch responder, 32-bit words from a 16-bit SDRAM bank
// Optional next-word prefetch with a second entry: JTKICKER_OBJROM_PREFETCH_EN
module jtkicker_objrom_resp
    import jtkicker_objrom_pkg::*;
#(
    parameter int                  AW   = 12,
    parameter logic [SDRAM_AW-1:0] BASE = 22'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rom_cs,
    input  logic [AW-1:0]       rom_addr,
    output logic [DW-1:0]       rom_data,
    output logic                rom_ok,
    input  logic                prog_en,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                sdram_dst,
    input  logic [BEAT_W-1:0]   sdram_din
);

    logic [2:0]        state;
    logic [AW-1:0]     fill_addr;
    logic [BEAT_W-1:0] lo_beat;
    logic              fill_dis;
    logic              done;
    logic              load_valid;
    logic [DW-1:0]     fill_data;
    logic              hit;

    logic              hit0;
    logic              valid0;
    logic [AW-1:0]     tag0;
    logic [DW-1:0]     data0;

    assign sdram_req  = (state == ST_REQ) || (state == ST_PF_REQ);
    assign sdram_addr = BASE + SDRAM_AW'({fill_addr, 1'b0});
    assign done       = sdram_dst && ((state == ST_WAIT_HI) || (state == ST_PF_HI));
    // a burst that overlapped a ROM download carries stale data
    assign load_valid = ~fill_dis & ~prog_en;
    assign fill_data  = {sdram_din, lo_beat};
    assign rom_ok     = rom_cs & hit;

`ifdef JTKICKER_OBJROM_PREFETCH_EN
    logic              hit1;
    logic              valid1;
    logic [AW-1:0]     tag1;
    logic [DW-1:0]     data1;
    logic              fill_sel;
    logic              mru;
    logic [AW-1:0]     next_addr;
    logic              next_present;

    jtkicker_objrom_entry #(.AW(AW)) u_entry0 (
        .clk        (clk),
        .rst        (rst),
        .clr        (prog_en),
        .load       (done & ~fill_sel),
        .load_valid (load_valid),
        .load_tag   (fill_addr),
        .load_data  (fill_data),
        .cmp_addr   (rom_addr),
        .hit        (hit0),
        .valid      (valid0),
        .tag        (tag0),
        .data       (data0)
    );

    jtkicker_objrom_entry #(.AW(AW)) u_entry1 (
        .clk        (clk),
        .rst        (rst),
        .clr        (prog_en),
        .load       (done & fill_sel),
        .load_valid (load_valid),
        .load_tag   (fill_addr),
        .load_data  (fill_data),
        .cmp_addr   (rom_addr),
        .hit        (hit1),
        .valid      (valid1),
        .tag        (tag1),
        .data       (data1)
    );

    assign hit          = hit0 | hit1;
    assign rom_data     = hit1 ? data1 : data0;
    assign next_addr    = fill_addr + AW'(1);
    // only the entry not being filled can already hold the following word
    assign next_present = fill_sel ? (valid0 && (tag0 == next_addr))
                                   : (valid1 && (tag1 == next_addr));
`else
    logic unused_entry;

    jtkicker_objrom_entry #(.AW(AW)) u_entry0 (
        .clk        (clk),
        .rst        (rst),
        .clr        (prog_en),
        .load       (done),
        .load_valid (load_valid),
        .load_tag   (fill_addr),
        .load_data  (fill_data),
        .cmp_addr   (rom_addr),
        .hit        (hit0),
        .valid      (valid0),
        .tag        (tag0),
        .data       (data0)
    );

    assign hit          = hit0;
    assign rom_data     = data0;
    assign unused_entry = &{1'b0, valid0, tag0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fill_addr <= '0;
            lo_beat   <= '0;
            fill_dis  <= 1'b0;
`ifdef JTKICKER_OBJROM_PREFETCH_EN
            fill_sel  <= 1'b0;
            mru       <= 1'b0;
`endif
        end else begin
`ifdef JTKICKER_OBJROM_PREFETCH_EN
            if (rom_ok) begin
                mru <= hit1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (rom_cs && !hit && !prog_en) begin
                        state     <= ST_REQ;
                        fill_addr <= rom_addr;
                        fill_dis  <= 1'b0;
`ifdef JTKICKER_OBJROM_PREFETCH_EN
                        fill_sel  <= ~mru;
`endif
                    end
                end
                ST_REQ: begin
                    // a strobe arriving with the ack is the low beat
                    if (sdram_ack) begin
                        if (sdram_dst) begin
                            lo_beat <= sdram_din;
                            state   <= ST_WAIT_HI;
                        end else begin
                            state   <= ST_WAIT_LO;
                        end
                    end else if (prog_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT_LO: begin
                    if (sdram_dst) begin
                        lo_beat <= sdram_din;
                        state   <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (sdram_dst) begin
                        state <= ST_IDLE;
`ifdef JTKICKER_OBJROM_PREFETCH_EN
                        mru   <= fill_sel;
                        if (rom_cs && !prog_en && !next_present) begin
                            state     <= ST_PF_REQ;
                            fill_addr <= next_addr;
                            fill_sel  <= ~fill_sel;
                            fill_dis  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef JTKICKER_OBJROM_PREFETCH_EN
                ST_PF_REQ: begin
                    if (sdram_ack) begin
                        if (sdram_dst) begin
                            lo_beat <= sdram_din;
                            state   <= ST_PF_HI;
                        end else begin
                            state   <= ST_PF_LO;
                        end
                    end else if (prog_en) begin
                        state <= ST_IDLE;
                    end
                end
                ST_PF_LO: begin
                    if (sdram_dst) begin
                        lo_beat <= sdram_din;
                        state   <= ST_PF_HI;
                    end
                end
                ST_PF_HI: begin
                    if (sdram_dst) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (prog_en) begin
                fill_dis <= 1'b1;
            end
        end
    end

endmodule
